// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / stall controller.
// Shadow entries are sized for the widest supported configuration
// (8-bit register index, 4-bit stage index); narrower ports are
// zero-extended when they are stored or compared.
package hazard_pkg;

   // Pipeline stage indices
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   // Stage at whose end a result becomes forwardable
   localparam int RDY_ALU  = 2;
   localparam int RDY_LOAD = 3;

   // Storage widths of the shadow entry fields
   localparam int SH_RD_W  = 8;
   localparam int SH_RDY_W = 4;

   typedef struct packed {
      logic                valid;
      logic [SH_RD_W-1:0]  rd;
      logic [SH_RDY_W-1:0] rdy;
   } shadow_entry_t;

   // True when entry e, sitting in stage s, cannot yet supply operand src
   // to a consumer that needs it at stage need. slack is how many stages
   // the producer still has to travel before its result is forwardable.
   function automatic logic raw_hit(input shadow_entry_t      e,
                                    input int                 s,
                                    input logic [SH_RD_W-1:0] src,
                                    input int                 need);
      int slack;
      slack = int'(e.rdy) - s;
      return e.valid && (e.rd == src) && (src != '0) &&
             (slack >= 0) && (slack >= need - 1);
   endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow pipeline of in-flight destination registers (stages EX..last).
// Advances in lock-step with the datapath, holds while frozen, and
// reports per-stage RAW match vectors for the two ID source operands.
module hazard_shadow_pipe
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int REG_W      = 5,
   parameter int STG_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  ins_valid,
   input  logic [REG_W-1:0]      ins_rd,
   input  logic [STG_W-1:0]      ins_rdy,
   input  logic [REG_W-1:0]      rs1,
   input  logic [STG_W-1:0]      rs1_need,
   input  logic [REG_W-1:0]      rs2,
   input  logic [STG_W-1:0]      rs2_need,
   output logic [NUM_STAGES-1:0] rs1_match,
   output logic [NUM_STAGES-1:0] rs2_match
);

   shadow_entry_t entry [NUM_STAGES-1:STG_EX];

   // Shift the shadow one stage per non-frozen cycle; EX takes the ID instruction or a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: this array is reset because every valid bit must read 0 right after reset.
         for (int s = STG_EX; s < NUM_STAGES; s++) begin
            entry[s] <= '0;
         end
      end else if (advance) begin
         entry[STG_EX].valid <= ins_valid;
         entry[STG_EX].rd    <= SH_RD_W'(ins_rd);
         entry[STG_EX].rdy   <= SH_RDY_W'(ins_rdy);
         for (int s = STG_EX + 1; s < NUM_STAGES; s++) begin
            entry[s] <= entry[s-1];
         end
      end
   end

   // Per-stage RAW match for each source; IF/ID positions never match.
   always_comb begin
      // NOTE: defaults first so every path assigns every bit and no latch is inferred.
      rs1_match = '0;
      rs2_match = '0;
      for (int s = STG_EX; s < NUM_STAGES; s++) begin
         rs1_match[s] = raw_hit(entry[s], s, SH_RD_W'(rs1), int'(rs1_need));
         rs2_match[s] = raw_hit(entry[s], s, SH_RD_W'(rs2), int'(rs2_need));
      end
   end

endmodule

// File: rtl/hazard_shadow_ctrl.sv
// Pipeline stall/flush controller. Resolves cache freezes, EX/ID redirects
// and RAW hazards (via the shadow pipeline) into per-register load/flush
// enables and load_pc. Includes a freeze watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the three perf counters;
// without it perf_hazard/perf_mem/perf_flush are tied to 0.
module hazard_shadow_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int REG_W      = 5,
   parameter int STG_W      = 3,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_resp,
   input  logic                  dmem_req,
   input  logic                  dmem_resp,
   input  logic                  id_valid,
   input  logic [REG_W-1:0]      id_rs1,
   input  logic [REG_W-1:0]      id_rs2,
   input  logic                  id_rs1_use,
   input  logic                  id_rs2_use,
   input  logic [STG_W-1:0]      id_rs1_need,
   input  logic [STG_W-1:0]      id_rs2_need,
   input  logic [REG_W-1:0]      id_rd,
   input  logic                  id_rd_we,
   input  logic [STG_W-1:0]      id_rd_rdy,
   input  logic                  redirect_valid,
   input  logic [STG_W-1:0]      redirect_stage,
   output logic                  load_pc,
   output logic [NUM_STAGES-2:0] stage_load,
   output logic [NUM_STAGES-2:0] stage_flush,
   output logic                  global_stall,
   output logic                  hazard_stall,
   output logic                  hang_err,
   output logic [31:0]           perf_hazard,
   output logic [31:0]           perf_mem,
   output logic [31:0]           perf_flush
);

   logic                  freeze;
   logic                  ex_redirect;
   logic                  id_redirect;
   logic                  raw_hazard;
   logic                  ins_valid;
   logic [NUM_STAGES-1:0] rs1_match;
   logic [NUM_STAGES-1:0] rs2_match;

   assign freeze      = ~imem_resp | (dmem_req & ~dmem_resp);
   assign ex_redirect = redirect_valid & (redirect_stage == STG_W'(STG_EX));
   assign id_redirect = redirect_valid & (redirect_stage == STG_W'(STG_ID));
   assign raw_hazard  = id_valid & ((id_rs1_use & (|rs1_match)) |
                                    (id_rs2_use & (|rs2_match)));
   // The ID instruction moves to EX only when the ID/EX register is not bubbled.
   assign ins_valid   = id_valid & id_rd_we & (id_rd != '0) & ~stage_flush[STG_ID];

   hazard_shadow_pipe #(
      .NUM_STAGES (NUM_STAGES),
      .REG_W      (REG_W),
      .STG_W      (STG_W)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .advance   (~freeze),
      .ins_valid (ins_valid),
      .ins_rd    (id_rd),
      .ins_rdy   (id_rd_rdy),
      .rs1       (id_rs1),
      .rs1_need  (id_rs1_need),
      .rs2       (id_rs2),
      .rs2_need  (id_rs2_need),
      .rs1_match (rs1_match),
      .rs2_match (rs2_match)
   );

   // Priority resolution: reset, freeze, EX redirect, hazard, ID redirect, run.
   always_comb begin
      load_pc      = 1'b1;
      stage_load   = '1;
      stage_flush  = '0;
      global_stall = 1'b0;
      hazard_stall = 1'b0;
      if (!rst) begin
         load_pc     = 1'b0;
         stage_load  = '0;
         stage_flush = '1;
      end else if (freeze) begin
         load_pc      = 1'b0;
         stage_load   = '0;
         global_stall = 1'b1;
      end else if (ex_redirect) begin
         stage_flush[STG_IF] = 1'b1;
         stage_flush[STG_ID] = 1'b1;
      end else if (raw_hazard) begin
         load_pc             = 1'b0;
         stage_load[STG_IF]  = 1'b0;
         stage_flush[STG_ID] = 1'b1;
         hazard_stall        = 1'b1;
      end else if (id_redirect) begin
         stage_flush[STG_IF] = 1'b1;
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_wdog
         localparam int WD_W = $clog2(TIMEOUT + 1);
         logic [WD_W-1:0] wd_cnt;

         // Count consecutive freeze cycles (saturating); hang_err latches at TIMEOUT.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               wd_cnt   <= '0;
               hang_err <= 1'b0;
            end else if (freeze) begin
               if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
               if (wd_cnt == WD_W'(TIMEOUT - 1)) hang_err <= 1'b1;
            end else begin
               wd_cnt <= '0;
            end
         end
      end else begin : g_no_wdog
         assign hang_err = 1'b0;
      end
   endgenerate

`ifdef HAZARD_PERF_CNT_EN
   logic redirect_taken;
   assign redirect_taken = ~freeze & (ex_redirect | (id_redirect & ~raw_hazard));

   // Wrap-around event counters for hazard bubbles, freezes and accepted redirects.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_hazard <= '0;
         perf_mem    <= '0;
         perf_flush  <= '0;
      end else begin
         if (hazard_stall)   perf_hazard <= perf_hazard + 32'd1;
         if (freeze)         perf_mem    <= perf_mem + 32'd1;
         if (redirect_taken) perf_flush  <= perf_flush + 32'd1;
      end
   end
`else
   assign perf_hazard = '0;
   assign perf_mem    = '0;
   assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_hazard_shadow_ctrl.sv
// Directed self-checking bench for hazard_shadow_ctrl (5 stages, TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1
// unit later, well away from the next edge.
module tb_hazard_shadow_ctrl;
   import hazard_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_resp, dmem_req, dmem_resp;
   logic        id_valid, id_rs1_use, id_rs2_use, id_rd_we;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_rs1_need, id_rs2_need, id_rd_rdy;
   logic        redirect_valid;
   logic [2:0]  redirect_stage;
   logic        load_pc, global_stall, hazard_stall, hang_err;
   logic [3:0]  stage_load, stage_flush;
   logic [31:0] perf_hazard, perf_mem, perf_flush;
   logic [10:0] ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected control words {load_pc, stage_load, stage_flush, global_stall, hazard_stall}
   localparam logic [10:0] CW_RST = {1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0};
   localparam logic [10:0] CW_RUN = {1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0};
   localparam logic [10:0] CW_FRZ = {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
   localparam logic [10:0] CW_EXR = {1'b1, 4'b1111, 4'b0011, 1'b0, 1'b0};
   localparam logic [10:0] CW_HAZ = {1'b0, 4'b1110, 4'b0010, 1'b0, 1'b1};
   localparam logic [10:0] CW_IDR = {1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0};

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   assign ctl = {load_pc, stage_load, stage_flush, global_stall, hazard_stall};

   always #5 clk = ~clk;

   hazard_shadow_ctrl #(
      .NUM_STAGES (5),
      .REG_W      (5),
      .STG_W      (3),
      .TIMEOUT    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_resp      (imem_resp),
      .dmem_req       (dmem_req),
      .dmem_resp      (dmem_resp),
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rs1_use     (id_rs1_use),
      .id_rs2_use     (id_rs2_use),
      .id_rs1_need    (id_rs1_need),
      .id_rs2_need    (id_rs2_need),
      .id_rd          (id_rd),
      .id_rd_we       (id_rd_we),
      .id_rd_rdy      (id_rd_rdy),
      .redirect_valid (redirect_valid),
      .redirect_stage (redirect_stage),
      .load_pc        (load_pc),
      .stage_load     (stage_load),
      .stage_flush    (stage_flush),
      .global_stall   (global_stall),
      .hazard_stall   (hazard_stall),
      .hang_err       (hang_err),
      .perf_hazard    (perf_hazard),
      .perf_mem       (perf_mem),
      .perf_flush     (perf_flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v,
                         input logic [4:0] rs1, input logic u1, input logic [2:0] n1,
                         input logic [4:0] rs2, input logic u2, input logic [2:0] n2,
                         input logic [4:0] rd, input logic we, input logic [2:0] rdy);
      id_valid = v;
      id_rs1 = rs1; id_rs1_use = u1; id_rs1_need = n1;
      id_rs2 = rs2; id_rs2_use = u2; id_rs2_need = n2;
      id_rd = rd; id_rd_we = we; id_rd_rdy = rdy;
   endtask

   task automatic idle_inputs();
      imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
      redirect_valid = 1'b0; redirect_stage = 3'd0;
      set_id(1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #1;
      n_checks++; if (ctl !== CW_RST) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CW_RST); end
      n_checks++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL reset_hang got=%b exp=0", hang_err); end
      n_checks++; if ({perf_hazard, perf_mem, perf_flush} !== 96'd0) begin n_fail++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_hazard, perf_mem, perf_flush); end
      tick(); tick();
      rst = 1'b1;
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, CW_RUN); end
   endtask

   // add x5 (ALU) then beq x5 at ID compare -> one bubble
   task automatic test_alu_branch();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd5, 1'b1, 3'(RDY_ALU));
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL alu_br_issue got=%b exp=%b", ctl, CW_RUN); end
      tick();
      set_id(1'b1, 5'd5, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_HAZ) begin n_fail++; $display("FAIL alu_br_bubble got=%b exp=%b", ctl, CW_HAZ); end
      tick();
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL alu_br_proceed got=%b exp=%b", ctl, CW_RUN); end
      tick();
   endtask

   // lw x6 then add x6 (EX use) -> 1 bubble; lw x6 then beq x6 (rs2, ID use) -> 2 bubbles
   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd6, 1'b1, 3'(RDY_LOAD));
      tick();
      set_id(1'b1, 5'd6, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd7, 1'b1, 3'(RDY_ALU));
      #1;
      n_checks++; if (ctl !== CW_HAZ) begin n_fail++; $display("FAIL ld_add_bubble got=%b exp=%b", ctl, CW_HAZ); end
      tick();
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL ld_add_proceed got=%b exp=%b", ctl, CW_RUN); end
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd6, 1'b1, 3'(RDY_LOAD));
      tick();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd6, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (ctl !== CW_HAZ) begin n_fail++; $display("FAIL ld_beq_bubble%0d got=%b exp=%b", i, ctl, CW_HAZ); end
         tick();
      end
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL ld_beq_proceed got=%b exp=%b", ctl, CW_RUN); end
      tick();
   endtask

   // Cases that must not stall
   task automatic test_no_stall();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b1, 3'(RDY_LOAD));
      tick();
      set_id(1'b1, 5'd0, 1'b1, 3'd1, 5'd0, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, CW_RUN); end
      tick();
      // ALU producer in EX forwards to an EX-stage consumer
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd7, 1'b1, 3'(RDY_ALU));
      tick();
      set_id(1'b1, 5'd7, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL alu_fwd_ex got=%b exp=%b", ctl, CW_RUN); end
      tick();
      // x7 now in MEM and WB, past its ready stage
      set_id(1'b1, 5'd7, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL past_rdy_s%0d got=%b exp=%b", i + 3, ctl, CW_RUN); end
         tick();
      end
      // Unused source never stalls
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd9, 1'b1, 3'(RDY_LOAD));
      tick();
      set_id(1'b1, 5'd9, 1'b0, 3'd1, 5'd9, 1'b0, 3'd1, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL unused_src got=%b exp=%b", ctl, CW_RUN); end
      tick();
   endtask

   // D-cache miss over a pending load-use hazard
   task automatic test_freeze();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd6, 1'b1, 3'(RDY_LOAD));
      tick();
      set_id(1'b1, 5'd6, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      dmem_req = 1'b1; dmem_resp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (ctl !== CW_FRZ) begin n_fail++; $display("FAIL freeze_c%0d got=%b exp=%b", i, ctl, CW_FRZ); end
         tick();
      end
      dmem_req = 1'b0;
      #1;
      n_checks++; if (ctl !== CW_HAZ) begin n_fail++; $display("FAIL freeze_hazard_kept got=%b exp=%b", ctl, CW_HAZ); end
      tick();
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL freeze_resolved got=%b exp=%b", ctl, CW_RUN); end
      n_checks++; if (perf_mem !== (PERF_ON ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL perf_mem got=%0d exp=%0d", perf_mem, PERF_ON ? 5 : 0); end
      n_checks++; if (perf_hazard !== (PERF_ON ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL perf_hazard got=%0d exp=%0d", perf_hazard, PERF_ON ? 1 : 0); end
      // Freeze outranks a redirect
      imem_resp = 1'b0; redirect_valid = 1'b1; redirect_stage = 3'd2;
      #1;
      n_checks++; if (ctl !== CW_FRZ) begin n_fail++; $display("FAIL freeze_over_redirect got=%b exp=%b", ctl, CW_FRZ); end
      idle_inputs();
      tick();
   endtask

   // EX redirect over an ID hazard, ID redirect and its interplay with hazards
   task automatic test_redirect();
      do_reset();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd5, 1'b1, 3'(RDY_ALU));
      tick();
      set_id(1'b1, 5'd5, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd9, 1'b1, 3'(RDY_ALU));
      redirect_valid = 1'b1; redirect_stage = 3'd2;
      #1;
      n_checks++; if (ctl !== CW_EXR) begin n_fail++; $display("FAIL exr_over_hazard got=%b exp=%b", ctl, CW_EXR); end
      tick();
      redirect_valid = 1'b0;
      set_id(1'b1, 5'd9, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_RUN) begin n_fail++; $display("FAIL exr_rd_not_shadowed got=%b exp=%b", ctl, CW_RUN); end
      tick();
      // jal x1 with ID redirect: flushes IF/ID and still enters the shadow
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd1, 1'b1, 3'(RDY_ALU));
      redirect_valid = 1'b1; redirect_stage = 3'd1;
      #1;
      n_checks++; if (ctl !== CW_IDR) begin n_fail++; $display("FAIL idr_plain got=%b exp=%b", ctl, CW_IDR); end
      tick();
      set_id(1'b1, 5'd1, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
      #1;
      n_checks++; if (ctl !== CW_HAZ) begin n_fail++; $display("FAIL idr_under_hazard got=%b exp=%b", ctl, CW_HAZ); end
      tick();
      #1;
      n_checks++; if (ctl !== CW_IDR) begin n_fail++; $display("FAIL idr_reasserted got=%b exp=%b", ctl, CW_IDR); end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (perf_flush !== (PERF_ON ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL perf_flush got=%0d exp=%0d", perf_flush, PERF_ON ? 3 : 0); end
      idle_inputs();
      tick();
   endtask

   // Watchdog with TIMEOUT=4
   task automatic test_watchdog();
      do_reset();
      imem_resp = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      imem_resp = 1'b1;
      tick();
      imem_resp = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      n_checks++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL wd_cleared_by_gap got=%b exp=0", hang_err); end
      do_reset();
      imem_resp = 1'b0;
      #1;
      n_checks++; if (ctl !== CW_FRZ) begin n_fail++; $display("FAIL wd_freeze_ctl got=%b exp=%b", ctl, CW_FRZ); end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++; if (hang_err !== (i == 4)) begin n_fail++; $display("FAIL wd_cycle%0d got=%b exp=%b", i, hang_err, (i == 4)); end
      end
      imem_resp = 1'b1;
      tick(); tick();
      n_checks++; if (hang_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got=%b exp=1", hang_err); end
      rst = 1'b0;
      #1;
      n_checks++; if (hang_err !== 1'b0) begin n_fail++; $display("FAIL wd_cleared_by_rst got=%b exp=0", hang_err); end
      n_checks++; if (ctl !== CW_RST) begin n_fail++; $display("FAIL wd_rst_ctl got=%b exp=%b", ctl, CW_RST); end
      tick();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu_branch();
      test_load_use();
      test_no_stall();
      test_freeze();
      test_redirect();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
